// File: rtl/l1a_lct_matcher_if.sv
// Trigger-side bundle for the L1A/LCT matcher: strobe, LCT vector and delay in,
// readout pulse, match mask and L1A count out.
interface l1a_lct_matcher_if #(
   parameter int NCH  = 8,
   parameter int CNTW = 24
);
   logic            en;
   logic            l1a;
   logic [NCH-1:0]  lct;
   logic [6:0]      lct_l1a_dly;
   logic            l1a_out;
   logic [NCH-1:0]  l1a_match;
   logic            l1a_nomatch;
   logic [CNTW-1:0] l1a_cnt;

   modport master (
      output en, l1a, lct, lct_l1a_dly,
      input  l1a_out, l1a_match, l1a_nomatch, l1a_cnt
   );

   modport slave (
      input  en, l1a, lct, lct_l1a_dly,
      output l1a_out, l1a_match, l1a_nomatch, l1a_cnt
   );
endinterface

// File: rtl/l1a_lct_matcher.sv
// Matches accepted L1As against a per-channel LCT history inside a delayed window,
// marking credited LCT pulses so later L1As cannot reuse them.
module l1a_lct_matcher #(
   parameter int NCH   = 8,
   parameter int DEPTH = 128,
   parameter int WIN   = 3,
   parameter int CNTW  = 24
) (
   input  logic clk,
   input  logic rst_n,
   l1a_lct_matcher_if.slave bus
);
   localparam int DMAX = DEPTH - WIN;

   // Age 0 is the live lct input; ages 1..DEPTH-1 live in the shift registers.
   logic [NCH-1:0] hist_reg [1:DEPTH-1];
   logic [NCH-1:0] cons_reg [1:DEPTH-1];

   logic [NCH-1:0] age_val      [0:DEPTH-1];
   logic [NCH-1:0] age_cons     [0:DEPTH-1];
   logic [NCH-1:0] age_live     [0:DEPTH-1];
   logic [NCH-1:0] age_cons_next[0:DEPTH-1];
   logic [DEPTH-1:0] in_win;

   logic            accept;
   logic [6:0]      d_eff;
   logic [NCH-1:0]  mask;

   logic            l1a_out_reg;
   logic [NCH-1:0]  l1a_match_reg;
   logic            l1a_nomatch_reg;
   logic [CNTW-1:0] l1a_cnt_reg;

   assign accept = bus.en & bus.l1a;
   assign d_eff  = (int'(bus.lct_l1a_dly) > DMAX) ? 7'(DMAX) : bus.lct_l1a_dly;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
         if (gi == 0) begin : g_live
            assign age_val[gi]  = bus.lct;
            assign age_cons[gi] = '0;
         end else begin : g_hist
            assign age_val[gi]  = hist_reg[gi];
            assign age_cons[gi] = cons_reg[gi];
         end
         assign in_win[gi] = accept && (gi >= int'(d_eff)) && (gi < int'(d_eff) + WIN);
         assign age_live[gi] = age_val[gi] & ~age_cons[gi] & {NCH{in_win[gi]}};
         // Every set bit in the window gets flagged; already-consumed ones stay consumed.
         assign age_cons_next[gi] = age_cons[gi] | (age_val[gi] & {NCH{in_win[gi]}});
      end
   endgenerate

   always_comb begin
      mask = '0;
      for (int k = 0; k < DEPTH; k++) begin
         mask = mask | age_live[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 1; k < DEPTH; k++) begin
            hist_reg[k] <= '0;
            cons_reg[k] <= '0;
         end
         l1a_out_reg     <= 1'b0;
         l1a_match_reg   <= '0;
         l1a_nomatch_reg <= 1'b0;
         l1a_cnt_reg     <= '0;
      end else begin
         hist_reg[1] <= bus.lct;
         cons_reg[1] <= age_cons_next[0];
         for (int k = 2; k < DEPTH; k++) begin
            hist_reg[k] <= hist_reg[k-1];
            cons_reg[k] <= age_cons_next[k-1];
         end
         l1a_out_reg     <= accept;
         l1a_match_reg   <= accept ? mask : '0;
         l1a_nomatch_reg <= accept && (mask == '0);
         if (accept) begin
            l1a_cnt_reg <= l1a_cnt_reg + 1'b1;
         end
      end
   end

   assign bus.l1a_out     = l1a_out_reg;
   assign bus.l1a_match   = l1a_match_reg;
   assign bus.l1a_nomatch = l1a_nomatch_reg;
   assign bus.l1a_cnt     = l1a_cnt_reg;
endmodule

// File: tb/tb_l1a_lct_matcher.sv
// Directed checks of the L1A/LCT matcher: window edges, reuse suppression,
// enable gating, reset, delay saturation and counter wrap (narrow counter).
module tb_l1a_lct_matcher;
   localparam int NCH  = 8;
   localparam int CNTW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   l1a_lct_matcher_if #(.NCH(NCH), .CNTW(CNTW)) bus ();

   l1a_lct_matcher #(.NCH(NCH), .DEPTH(128), .WIN(3), .CNTW(CNTW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic o, input logic [7:0] m,
                          input logic nm, input logic [7:0] c);
      chk({tag, ".out"},     32'(bus.l1a_out),     32'(o));
      chk({tag, ".match"},   32'(bus.l1a_match),   32'(m));
      chk({tag, ".nomatch"}, 32'(bus.l1a_nomatch), 32'(nm));
      chk({tag, ".cnt"},     32'(bus.l1a_cnt),     32'(c));
      $display("%0t %s out=%0d match=%02h nomatch=%0d cnt=%0d", $time, tag,
               bus.l1a_out, bus.l1a_match, bus.l1a_nomatch, bus.l1a_cnt);
   endtask

   task automatic tick(input logic [7:0] l, input logic a);
      bus.lct = l;
      bus.l1a = a;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(8'h00, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(8'h00, 1'b0);
      tick(8'h00, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      bus.en = 1'b1;
      bus.l1a = 1'b0;
      bus.lct = '0;
      bus.lct_l1a_dly = 7'd10;

      do_reset();
      chk_out("reset", 1'b0, 8'h00, 1'b0, 8'd0);

      // Basic match: lct at A, l1a at A+11
      tick(8'h05, 1'b0); idle(10); tick(8'h00, 1'b1);
      chk_out("basic", 1'b1, 8'h05, 1'b0, 8'd1);
      tick(8'h00, 1'b0);
      chk_out("basic_idle", 1'b0, 8'h00, 1'b0, 8'd1);

      // Window edges
      do_reset();
      tick(8'h80, 1'b0); idle(9); tick(8'h00, 1'b1);
      chk_out("win_near", 1'b1, 8'h80, 1'b0, 8'd1);
      do_reset();
      tick(8'h80, 1'b0); idle(12); tick(8'h00, 1'b1);
      chk_out("win_late", 1'b1, 8'h00, 1'b1, 8'd1);
      do_reset();
      tick(8'h80, 1'b0); idle(8); tick(8'h00, 1'b1);
      chk_out("win_early", 1'b1, 8'h00, 1'b1, 8'd1);

      // Reuse suppression, back-to-back
      do_reset();
      tick(8'h01, 1'b0); idle(10); tick(8'h00, 1'b1);
      chk_out("reuse_1st", 1'b1, 8'h01, 1'b0, 8'd1);
      tick(8'h00, 1'b1);
      chk_out("reuse_2nd", 1'b1, 8'h00, 1'b1, 8'd2);

      // All window entries consumed, not just one
      do_reset();
      tick(8'h01, 1'b0); tick(8'h01, 1'b0); idle(10); tick(8'h00, 1'b1);
      chk_out("multi_1st", 1'b1, 8'h01, 1'b0, 8'd1);
      tick(8'h00, 1'b1);
      chk_out("multi_2nd", 1'b1, 8'h00, 1'b1, 8'd2);

      // en=0 neither pulses, counts nor consumes
      do_reset();
      tick(8'h04, 1'b0); idle(10);
      bus.en = 1'b0; tick(8'h00, 1'b1);
      chk_out("en0", 1'b0, 8'h00, 1'b0, 8'd0);
      bus.en = 1'b1; tick(8'h00, 1'b1);
      chk_out("en0_noconsume", 1'b1, 8'h04, 1'b0, 8'd1);

      // d=0: same-cycle lct is usable
      bus.lct_l1a_dly = 7'd0;
      tick(8'h02, 1'b1);
      chk_out("d0", 1'b1, 8'h02, 1'b0, 8'd2);

      // Mid-operation reset discards prior LCTs
      bus.lct_l1a_dly = 7'd10;
      do_reset();
      tick(8'hFF, 1'b0); idle(4);
      rst_n = 1'b0; tick(8'h00, 1'b0); rst_n = 1'b1;
      idle(5); tick(8'h00, 1'b1);
      chk_out("midreset", 1'b1, 8'h00, 1'b1, 8'd1);

      // Delay saturation: 127 acts as 125
      bus.lct_l1a_dly = 7'd127;
      do_reset();
      tick(8'h08, 1'b0); idle(125); tick(8'h00, 1'b1);
      chk_out("sat_hit", 1'b1, 8'h08, 1'b0, 8'd1);
      do_reset();
      tick(8'h08, 1'b0); idle(127); tick(8'h00, 1'b1);
      chk_out("sat_miss", 1'b1, 8'h00, 1'b1, 8'd1);

      // Counter wrap
      bus.lct_l1a_dly = 7'd10;
      do_reset();
      for (int i = 0; i < (1 << CNTW); i++) begin
         tick(8'h00, 1'b1);
         if (i == (1 << CNTW) - 2) chk_out("wrap_pre", 1'b1, 8'h00, 1'b1, 8'hFF);
      end
      chk_out("wrap", 1'b1, 8'h00, 1'b1, 8'h00);
      tick(8'h00, 1'b0);
      chk_out("wrap_hold", 1'b0, 8'h00, 1'b0, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
